// File: rtl/lfsr_parity_checker.sv
// Link-integrity monitor for the {parity, lfsr[6:0]} word stream: checks even parity,
// locks a local 7-bit LFSR predictor onto the incoming sequence and counts errors.
module lfsr_parity_checker #(
  parameter logic [6:0] TAP_MASK      = 7'h60,
  parameter int         LOCK_COUNT    = 3,
  parameter int         UNLOCK_MISSES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] data_in,
  input  logic       clear_cnt,
  output logic       locked,
  output logic       parity_err,
  output logic       seq_err,
  output logic [7:0] err_count,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_MISSES);

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], ^(s & TAP_MASK)};
  endfunction

  function automatic logic even_parity_ok(input logic [7:0] w);
    return ~(^w);
  endfunction

  state_t     state_r, state_next_s;
  logic [6:0] pred_r, pred_next_s;
  logic [3:0] match_cnt_r, match_next_s;
  logic [3:0] miss_cnt_r, miss_next_s;
  logic [7:0] err_count_r, err_next_s;
  logic       locked_r, parity_err_r, seq_err_r;
  logic       perr_s, serr_s;
  logic       good_s, match_s, seed_ok_s;
  logic [6:0] field_s;

  // Next-state, predictor and error-pulse decode for the accepted word
  always_comb begin
    state_next_s = state_r;
    pred_next_s  = pred_r;
    match_next_s = match_cnt_r;
    miss_next_s  = miss_cnt_r;
    perr_s       = 1'b0;
    serr_s       = 1'b0;
    field_s      = data_in[6:0];
    good_s       = even_parity_ok(data_in);
    match_s      = good_s && (field_s == pred_r);
    // an all-zero field is the LFSR lock-up state, never usable as a seed
    seed_ok_s    = good_s && (field_s != 7'd0);

    if (in_valid) begin
      perr_s = ~good_s;
      case (state_r)
        HUNT: begin
          if (seed_ok_s) begin
            pred_next_s  = lfsr_step(field_s);
            match_next_s = 4'd0;
            state_next_s = VERIFY;
          end else begin
            state_next_s = HUNT;
          end
        end
        VERIFY: begin
          if (match_s) begin
            match_next_s = match_cnt_r + 4'd1;
            pred_next_s  = lfsr_step(pred_r);
            if ((match_cnt_r + 4'd1) == LOCK_CNT_C) begin
              state_next_s = LOCKED;
              miss_next_s  = 4'd0;
            end else begin
              state_next_s = VERIFY;
            end
          end else if (seed_ok_s) begin
            pred_next_s  = lfsr_step(field_s);
            match_next_s = 4'd0;
            state_next_s = VERIFY;
          end else begin
            state_next_s = HUNT;
          end
        end
        LOCKED: begin
          // flywheel: the predictor keeps running through mismatches
          pred_next_s = lfsr_step(pred_r);
          if (match_s) begin
            miss_next_s  = 4'd0;
            state_next_s = LOCKED;
          end else begin
            serr_s      = 1'b1;
            miss_next_s = miss_cnt_r + 4'd1;
            if ((miss_cnt_r + 4'd1) == UNLOCK_CNT_C) begin
              state_next_s = HUNT;
            end else begin
              state_next_s = LOCKED;
            end
          end
        end
        default: begin
          state_next_s = HUNT;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Saturating error counter; clear overrides a simultaneous error
  always_comb begin
    err_next_s = err_count_r;
    if (clear_cnt) begin
      err_next_s = 8'd0;
    end else if ((perr_s || serr_s) && (err_count_r != 8'hFF)) begin
      err_next_s = err_count_r + 8'd1;
    end else begin
      err_next_s = err_count_r;
    end
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= HUNT;
      pred_r       <= 7'd0;
      match_cnt_r  <= 4'd0;
      miss_cnt_r   <= 4'd0;
      err_count_r  <= 8'd0;
      locked_r     <= 1'b0;
      parity_err_r <= 1'b0;
      seq_err_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pred_r       <= pred_next_s;
      match_cnt_r  <= match_next_s;
      miss_cnt_r   <= miss_next_s;
      err_count_r  <= err_next_s;
      locked_r     <= (state_next_s == LOCKED);
      parity_err_r <= perr_s;
      seq_err_r    <= serr_s;
    end
  end

  assign locked     = locked_r;
  assign parity_err = parity_err_r;
  assign seq_err    = seq_err_r;
  assign err_count  = err_count_r;
  assign state_o    = state_r;

endmodule
